// File: rtl/alu_div_pkg.sv
// Shared constants and state encoding for the iterative MIPS div/divu unit.
// Contents: datapath width, iteration-counter width, divide-by-zero quotient,
// and the three-state sequencer encoding used by alu_div_32.
package alu_div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } div_state_t;

endpackage

// File: rtl/alu_div_32_sign_cond.sv
// Conditional two's-complement negate, purely combinational.
// Ports: in (value), negate (1 = return -in), out (result).
// Used for operand magnitudes and for the final sign fix of quotient/remainder.
module div_sign_cond #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in,
    input  logic             negate,
    output logic [WIDTH-1:0] out
);

    assign out = negate ? -in : in;

endmodule

// File: rtl/alu_div_32.sv
// Iterative 32-bit restoring divider for MIPS div/divu, one quotient bit per cycle.
// Ports: clk, rst_n, Start/Signed/SrcA/SrcB in; Quotient/Remainder/DivByZero
// registered results, Busy while running, Done one-cycle pulse 33 cycles after Start.
module alu_div_32
    import alu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);

    div_state_t state, state_nxt;

    logic [WIDTH-1:0]     divisor;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     src_a_raw;
    logic                 sign_q;
    logic                 sign_r;
    logic                 div_zero;
    logic [DIV_CNT_W-1:0] cnt;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] quo_fix, rem_fix;
    logic             a_neg, b_neg;

    assign a_neg = Signed & SrcA[WIDTH-1];
    assign b_neg = Signed & SrcB[WIDTH-1];

    // Magnitudes are treated as unsigned from here on; |0x80000000| stays
    // 0x80000000, which is what makes the signed-overflow case fall out naturally.
    div_sign_cond #(.WIDTH(WIDTH)) u_mag_a (.in(SrcA), .negate(a_neg),  .out(a_mag));
    div_sign_cond #(.WIDTH(WIDTH)) u_mag_b (.in(SrcB), .negate(b_neg),  .out(b_mag));
    div_sign_cond #(.WIDTH(WIDTH)) u_fix_q (.in(quo),  .negate(sign_q), .out(quo_fix));
    div_sign_cond #(.WIDTH(WIDTH)) u_fix_r (.in(rem),  .negate(sign_r), .out(rem_fix));

    // The dividend is shifted out of quo into rem while quotient bits shift in.
    // rem < divisor < 2^WIDTH, so the shifted remainder needs WIDTH+1 bits and
    // the trial subtraction one more bit on top to carry a reliable sign.
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] trial;
    logic             trial_ok;

    assign rem_sh   = {rem, quo[WIDTH-1]};
    assign trial    = {1'b0, rem_sh} - {2'b00, divisor};
    assign trial_ok = ~trial[WIDTH+1];

    assign Busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (Start) state_nxt = S_CALC;
            S_CALC:  if (cnt == '0) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divisor   <= '0;
            quo       <= '0;
            rem       <= '0;
            src_a_raw <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            div_zero  <= 1'b0;
            cnt       <= '0;
            Quotient  <= '0;
            Remainder <= '0;
            DivByZero <= 1'b0;
            Done      <= 1'b0;
        end else begin
            Done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (Start) begin
                        divisor   <= b_mag;
                        quo       <= a_mag;
                        rem       <= '0;
                        src_a_raw <= SrcA;
                        sign_q    <= a_neg ^ b_neg;
                        sign_r    <= a_neg;
                        div_zero  <= (SrcB == '0);
                        cnt       <= DIV_CNT_W'(WIDTH - 1);
                    end
                end
                S_CALC: begin
                    rem <= trial_ok ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], trial_ok};
                    cnt <= cnt - DIV_CNT_W'(1);
                end
                S_FIX: begin
                    Done      <= 1'b1;
                    DivByZero <= div_zero;
                    if (div_zero) begin
                        Quotient  <= DIV_BY_ZERO_Q;
                        Remainder <= src_a_raw;
                    end else begin
                        Quotient  <= quo_fix;
                        Remainder <= rem_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_div_32.sv
module tb_alu_div_32;

    logic        clk;
    logic        rst_n;
    logic        Start;
    logic        Signed;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [31:0] Quotient;
    logic [31:0] Remainder;
    logic        Busy;
    logic        Done;
    logic        DivByZero;

    int n_vec = 0;
    int n_bad = 0;

    alu_div_32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Start     (Start),
        .Signed    (Signed),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Reference: MIPS semantics straight from integer arithmetic. 64-bit
    // signed math keeps 0x80000000 / -1 from overflowing the model itself.
    task automatic ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r, output logic dz);
        longint sa, sb;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
        end else if (!s) begin
            q  = a / b;
            r  = a % b;
            dz = 1'b0;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
            dz = 1'b0;
        end
    endtask

    // Called at a negedge; returns at the negedge right after the start edge.
    task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
        Signed = s;
        SrcA   = a;
        SrcB   = b;
        Start  = 1'b1;
        @(negedge clk);
        Start  = 1'b0;
    endtask

    // c0 = cycles already elapsed since the start edge; lat counts from the start edge.
    task automatic wait_done(input int c0, output int lat, output int bcnt);
        lat  = -1;
        bcnt = Busy ? 1 : 0;
        for (int c = c0 + 1; c <= c0 + 45; c++) begin
            @(negedge clk);
            if (Busy) bcnt++;
            if (Done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic run_and_check(input string name, input logic s, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] q,
                                 input logic [31:0] r, input logic dz);
        int lat, bcnt;
        start_op(s, a, b);
        wait_done(0, lat, bcnt);
        chk({name, ".latency"}, 32'(lat), 32'd33);
        chk({name, ".busy_cycles"}, 32'(bcnt), 32'd33);
        chk({name, ".quotient"}, Quotient, q);
        chk({name, ".remainder"}, Remainder, r);
        chk({name, ".div_by_zero"}, {31'd0, DivByZero}, {31'd0, dz});
    endtask

    initial begin
        int          lat, bcnt, ndone;
        logic [31:0] q, r;
        logic        dz, s;
        logic [31:0] a, b;

        tbl[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        tbl[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
        tbl[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
        tbl[3] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0};
        tbl[4] = '{1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
        tbl[5] = '{1'b1, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
        tbl[6] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
        tbl[7] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
        tbl[8] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0};

        rst_n  = 1'b0;
        Start  = 1'b0;
        Signed = 1'b0;
        SrcA   = '0;
        SrcB   = '0;
        repeat (3) @(negedge clk);
        chk("reset.quotient",  Quotient, 32'd0);
        chk("reset.remainder", Remainder, 32'd0);
        chk("reset.busy",      {31'd0, Busy}, 32'd0);
        chk("reset.done",      {31'd0, Done}, 32'd0);
        chk("reset.dbz",       {31'd0, DivByZero}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_and_check($sformatf("tbl%0d", i), tbl[i].s, tbl[i].a, tbl[i].b,
                          tbl[i].q, tbl[i].r, tbl[i].dz);
            @(negedge clk);
        end

        // A second Start at cycle 10 with other operands must be ignored.
        start_op(1'b0, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        Signed = 1'b1;
        SrcA   = 32'd1000;
        SrcB   = 32'd3;
        Start  = 1'b1;
        @(negedge clk);
        Start  = 1'b0;
        SrcA   = 32'd55;
        wait_done(11, lat, bcnt);
        chk("ignore.latency",   32'(lat), 32'd33);
        chk("ignore.quotient",  Quotient, 32'd14);
        chk("ignore.remainder", Remainder, 32'd2);

        // Start in the Done cycle launches the next op immediately.
        start_op(1'b1, 32'hFFFF_FF9C, 32'd7);
        wait_done(0, lat, bcnt);
        chk("b2b.latency",   32'(lat), 32'd33);
        chk("b2b.quotient",  Quotient, 32'hFFFF_FFF2);
        chk("b2b.remainder", Remainder, 32'hFFFF_FFFE);

        // Results hold between operations regardless of input activity.
        SrcA = 32'hDEAD_BEEF;
        SrcB = 32'd0;
        repeat (5) @(negedge clk);
        chk("hold.quotient",  Quotient, 32'hFFFF_FFF2);
        chk("hold.remainder", Remainder, 32'hFFFF_FFFE);
        chk("hold.done",      {31'd0, Done}, 32'd0);

        // Reset mid-operation: immediate clear, no Done afterwards.
        start_op(1'b0, 32'd100, 32'd7);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst.quotient",  Quotient, 32'd0);
        chk("midrst.remainder", Remainder, 32'd0);
        chk("midrst.busy",      {31'd0, Busy}, 32'd0);
        chk("midrst.done",      {31'd0, Done}, 32'd0);
        chk("midrst.dbz",       {31'd0, DivByZero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (Done || Busy) ndone++;
        end
        chk("midrst.no_done", 32'(ndone), 32'd0);
        run_and_check("postrst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        @(negedge clk);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1, 2:    b = 32'($urandom_range(1, 255));
                3, 4:    b = -32'($urandom_range(1, 255));
                5:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if (i % 7 == 3) a = 32'h8000_0000;
            ref_div(s, a, b, q, r, dz);
            run_and_check($sformatf("rnd%0d", i), s, a, b, q, r, dz);
            if (i % 2 == 0) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_div_32.md
# alu_div_32

Iterative 32-bit integer divider serving MIPS `div`/`divu`: the multi-cycle inverse of the single-cycle ALU multiply path. It sits beside the ALU in the execute stage. It accepts a dividend/divisor pair on a start pulse and computes one quotient bit per cycle with a restoring shift-subtract loop. It then returns quotient and remainder, valid together with a one-cycle `Done` pulse.

## Interface
- `WIDTH`, 32: operand and result width. Only 32 is verified.
- `clk`  in  1  single clock; every register updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `Start`  in  1  request pulse; sampled only in IDLE.
- `Signed`  in  1  1 = `div` (two's complement), 0 = `divu`.
- `SrcA`  in  WIDTH  dividend; sampled with `Start`.
- `SrcB`  in  WIDTH  divisor; sampled with `Start`.
- `Quotient`  out  WIDTH  registered result.
- `Remainder`  out  WIDTH  registered result.
- `Busy`  out  1  high while a division is in progress.
- `Done`  out  1  one-cycle pulse; results are valid in that cycle.
- `DivByZero`  out  1  registered flag; valid with `Done`.

## Operation
- States:
  - IDLE -> CALC on `Start`.
  - CALC -> FIX after 32 iterations.
  - FIX -> IDLE unconditionally.
- Start edge (IDLE, `Start`=1):
  - Latch the magnitudes |SrcA| and |SrcB|. Magnitudes apply only when `Signed`=1; otherwise use the raw values.
  - Latch sign_q = A[31]^B[31] and sign_r = A[31]. Both are forced to 0 when unsigned.
  - Latch div_zero = (SrcB==0) and the raw `SrcA`.
  - Clear the partial remainder and load the iteration counter with 31.
- CALC, once per edge:
  - Form {rem, quo} shifted left 1.
  - Compute trial = rem_shifted − divisor, in WIDTH+1 bits.
  - If trial ≥ 0: rem = trial and the new quotient LSB = 1. Otherwise keep rem and the LSB = 0.
  - Decrement the counter; leave CALC after the iteration with counter==0.
- FIX edge:
  - `Quotient` = sign_q ? −quo : quo.
  - `Remainder` = sign_r ? −rem : rem.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero: in FIX, force `Quotient`=32'hFFFFFFFF, `Remainder`=raw latched `SrcA` and `DivByZero`=1, regardless of `Signed`. Latency is unchanged.
- Signed overflow (0x80000000 / 0xFFFFFFFF): `Quotient`=0x80000000, `Remainder`=0, `DivByZero`=0. The unsigned-magnitude datapath yields this with no special case.
- `Start` while not in IDLE is ignored. Operands sampled at the accepted start are held internally, so later changes to `SrcA`/`SrcB` have no effect.
- `Quotient`, `Remainder` and `DivByZero` hold their values from `Done` until the next FIX edge.

## Timing
- Reset (async assert, any state):
  - State = IDLE.
  - `Quotient`=0, `Remainder`=0, `Busy`=0, `Done`=0, `DivByZero`=0.
  - The in-flight operation is aborted; no `Done` follows.
- Label the start edge as edge 0.
  - CALC occupies edges 1..32.
  - FIX is edge 33.
  - `Done`=1 for exactly the cycle after edge 33.
  - Total latency is 33 cycles from the accepted `Start`.
- `Busy` is driven from the state register:
  - It is 1 after edge 0 through edge 32.
  - It is 0 in the `Done` cycle.
- Back-to-back operation: `Start` asserted in the `Done` cycle (state IDLE) is accepted. The next `Done` comes 33 cycles later.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `alu_div_pkg`:
  - State encoding localparams (S_IDLE, S_CALC, S_FIX).
  - `DIV_WIDTH`=32.
  - `DIV_CNT_W`=$clog2(DIV_WIDTH).
  - `DIV_BY_ZERO_Q`=32'hFFFFFFFF.
- One sub-module, `div_sign_cond`: combinational conditional two's-complement negate (in, negate) -> out. It is instantiated for operand magnitudes and for result sign fix.
- The FSM, counter and shift-subtract datapath stay in `alu_div_32`.

## Test plan
- Unsigned: `Signed`=0, `SrcA`=100, `SrcB`=7, `Start` pulse.
  - Expect `Busy` 1 for 33 cycles.
  - Expect `Done` at cycle 33, `Quotient`=14, `Remainder`=2, `DivByZero`=0.
- Signed negative: `Signed`=1, −7 / 2.
  - Expect `Quotient`=0xFFFFFFFD (−3) and `Remainder`=0xFFFFFFFF (−1).
  - 7 / −2 gives `Quotient`=−3, `Remainder`=1.
- Divide by zero: 0x12345678 / 0, both with `Signed`=0 and with `Signed`=1.
  - Expect `Quotient`=0xFFFFFFFF, `Remainder`=0x12345678, `DivByZero`=1 at cycle 33.
- Overflow: `Signed`=1, 0x80000000 / 0xFFFFFFFF.
  - Expect `Quotient`=0x80000000, `Remainder`=0.
  - Unsigned 0xFFFFFFFF / 1 gives `Quotient`=0xFFFFFFFF, `Remainder`=0.
- Handshake:
  - A second `Start` with different operands at cycle 10 is ignored; the first result is returned.
  - `Start` in the `Done` cycle launches the next op, whose `Done` arrives 33 cycles later.
  - Outputs hold between operations.
- Reset mid-op: assert `rst_n`=0 at cycle 15.
  - Expect all outputs to go to 0 immediately and no `Done` to follow.
  - After release, a new 100/7 completes normally.
